// File: rtl/legv8_mem_interface.sv
// Memory bus bridge between the LEGv8 datapath and RAM: turns a one-shot En_Ram
// request into a req/ready handshake, stalling the core and flagging bad accesses.
module legv8_mem_interface #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int ALIGN_BITS = 3,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_enable,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clear,
  output logic              err_align,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  wait_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);

  state_t            state_q;
  logic              mem_req_q, mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q, cpu_rdata_q;
  logic              err_align_q, err_timeout_q;
  logic [CNT_W-1:0]  access_cnt_q, wait_cnt_q;
  logic [TW-1:0]     tcnt_q;

  logic [CNT_W-1:0]  access_cnt_d, wait_cnt_d;
  logic              misaligned;
  logic              timed_out;

  assign misaligned   = |(cpu_address & ALIGN_MASK);
  assign timed_out    = (TIMEOUT != 0) && (tcnt_q == TO_LAST);
  assign access_cnt_d = (&access_cnt_q) ? access_cnt_q : access_cnt_q + CNT_W'(1);
  assign wait_cnt_d   = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      access_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      tcnt_q        <= '0;
    end else begin
      // Clear first so a same-cycle set below wins.
      if (err_clear) begin
        err_align_q   <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: if (cpu_enable) begin
          mem_write_q   <= cpu_write;
          mem_address_q <= cpu_address;
          mem_wdata_q   <= cpu_wdata;
          if (misaligned) begin
            state_q     <= FAULT;
            err_align_q <= 1'b1;
            cpu_rdata_q <= '0;
          end else begin
            state_q   <= BUSY;
            mem_req_q <= 1'b1;
            tcnt_q    <= '0;
          end
        end
        BUSY: if (mem_ready) begin
          state_q      <= DONE;
          mem_req_q    <= 1'b0;
          access_cnt_q <= access_cnt_d;
          if (!mem_write_q) cpu_rdata_q <= mem_rdata;
        end else if (timed_out) begin
          // The expiring cycle ends the access rather than counting as another wait.
          state_q       <= FAULT;
          mem_req_q     <= 1'b0;
          err_timeout_q <= 1'b1;
          cpu_rdata_q   <= '0;
        end else begin
          tcnt_q     <= tcnt_q + TW'(1);
          wait_cnt_q <= wait_cnt_d;
        end
        DONE:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_stall   = ((state_q == IDLE) && cpu_enable) || (state_q == BUSY);
  assign cpu_rdata   = cpu_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;
  assign access_cnt  = access_cnt_q;
  assign wait_cnt    = wait_cnt_q;

endmodule

// File: tb/tb_legv8_mem_interface.sv
// Bench for legv8_mem_interface: directed vector table, mid-access reset, counter
// saturation and random accesses checked cycle by cycle against a transaction model.
module tb_legv8_mem_interface;
  localparam int TO  = 4;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0, reset = 1'b1;
  logic          cpu_enable = 1'b0, cpu_write = 1'b0, mem_ready = 1'b0, err_clear = 1'b0;
  logic [63:0]   cpu_address = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [63:0]   cpu_rdata, mem_address, mem_wdata;
  logic          cpu_stall, mem_req, mem_write, err_align, err_timeout;
  logic [CW-1:0] access_cnt, wait_cnt;

  legv8_mem_interface #(.DATA_W(64), .ADDR_W(64), .ALIGN_BITS(3), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .err_clear(err_clear), .err_align(err_align),
    .err_timeout(err_timeout), .access_cnt(access_cnt), .wait_cnt(wait_cnt));

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  // Transaction-level model state
  logic [63:0] m_rdata = '0;
  int          m_acc = 0, m_wait = 0;
  logic        m_ea = 1'b0, m_et = 1'b0;
  logic        m_term = 1'b0;   // DUT sits in its DONE/FAULT cycle

  typedef struct {
    logic wr; logic [63:0] addr, wd, rd; int lat; int clr; int exp_busy; logic exp_fault;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive_clr(input int clr);
    err_clear = (clr == 2) ? 1'b1 : (clr == 1) ? 1'($urandom % 2) : 1'b0;
  endtask

  // One clock edge; sticky flags follow set-over-clear.
  task automatic step(input logic sa, input logic st);
    m_ea = sa | (m_ea & ~err_clear);
    m_et = st | (m_et & ~err_clear);
    @(posedge clock); #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, m_rdata);
    chk({tag, "_acc"}, 64'(access_cnt), 64'(m_acc));
    chk({tag, "_wait"}, 64'(wait_cnt), 64'(m_wait));
    chk({tag, "_ealign"}, 64'(err_align), 64'(m_ea));
    chk({tag, "_etimeout"}, 64'(err_timeout), 64'(m_et));
  endtask

  task automatic access(input logic wr, input logic [63:0] addr, wd, rd, input int lat, clr,
                        output int busy, output logic fault);
    logic [CW-1:0] acc0;
    logic mis, fin, to;
    int cyc;
    busy = 0;
    mis = (addr[2:0] != 3'd0);
    cpu_enable = 1'b1; cpu_write = wr; cpu_address = addr; cpu_wdata = wd;
    mem_ready = 1'($urandom % 2); mem_rdata = {$urandom, $urandom};
    drive_clr(clr);
    if (m_term) begin
      // Request presented during DONE/FAULT is only taken in the following IDLE.
      #1 chk("stall_term", 64'(cpu_stall), 64'd0);
      step(1'b0, 1'b0);
      m_term = 1'b0;
      chk_regs("idle");
      chk("req_idle", 64'(mem_req), 64'd0);
    end
    acc0 = access_cnt;
    #1 chk("stall_idle", 64'(cpu_stall), 64'd1);
    if (mis) m_rdata = '0;
    step(mis, 1'b0);
    cpu_enable = 1'($urandom % 2); cpu_write = 1'($urandom % 2);
    cpu_address = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom};
    #1;
    if (!mis) begin
      cyc = 0; fin = 1'b0;
      while (!fin) begin
        chk("busy_req", 64'(mem_req), 64'd1);
        if (mem_req) busy++;
        chk("busy_stall", 64'(cpu_stall), 64'd1);
        chk("busy_write", 64'(mem_write), 64'(wr));
        chk("busy_addr", mem_address, addr);
        chk("busy_wdata", mem_wdata, wd);
        mem_ready = (cyc == lat);
        mem_rdata = (cyc == lat) ? rd : {$urandom, $urandom};
        drive_clr(clr);
        to = 1'b0;
        if (cyc == lat) begin
          m_acc = sat(m_acc + 1);
          if (!wr) m_rdata = rd;
          fin = 1'b1;
        end else if (cyc == TO - 1) begin
          to = 1'b1; m_rdata = '0; fin = 1'b1;
        end else m_wait = sat(m_wait + 1);
        step(1'b0, to);
        cyc++;
      end
    end
    chk("end_stall", 64'(cpu_stall), 64'd0);
    chk("end_req", 64'(mem_req), 64'd0);
    chk_regs("end");
    fault = (access_cnt == acc0);
    m_term = 1'b1;
  endtask

  initial begin
    int busy;
    logic fault;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    logic fault;
    vt[0] = '{1'b0, 64'h40,  64'h0,    64'hDEAD, 0, 0, 1, 1'b0};
    vt[1] = '{1'b1, 64'h80,  64'h1234, 64'h0,    3, 0, 4, 1'b0};
    vt[2] = '{1'b0, 64'h44,  64'h0,    64'h55,   0, 0, 0, 1'b1};
    vt[3] = '{1'b0, 64'h100, 64'h0,    64'hBEEF, 9, 0, 4, 1'b1};
    vt[4] = '{1'b0, 64'h48,  64'h0,    64'h1111, 0, 0, 1, 1'b0};
    vt[5] = '{1'b0, 64'h50,  64'h0,    64'h2222, 0, 0, 1, 1'b0};
    vt[6] = '{1'b1, 64'h13,  64'h77,   64'h0,    0, 2, 0, 1'b1};
    vt[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 2, 0, 3, 1'b0};
    vt[8] = '{1'b1, 64'h88,  64'hCAFE,  64'h0,   1, 2, 2, 1'b0};
    vt[9] = '{1'b0, 64'h90,  64'h0,    64'h3333, 3, 1, 4, 1'b0};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_rdata", cpu_rdata, 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_addr", mem_address, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk_regs("rst");

    foreach (vt[i]) begin
      access(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].lat, vt[i].clr, busy, fault);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].exp_busy));
      chk($sformatf("vec%0d_fault", i), 64'(fault), 64'(vt[i].exp_fault));
    end

    // Reset landing in the second BUSY cycle
    cpu_enable = 1'b0; err_clear = 1'b0; mem_ready = 1'b0;
    if (m_term) begin step(1'b0, 1'b0); m_term = 1'b0; end
    cpu_enable = 1'b1; cpu_write = 1'b0; cpu_address = 64'h200;
    step(1'b0, 1'b0);
    cpu_enable = 1'b0;
    chk("rstb_req1", 64'(mem_req), 64'd1);
    m_wait = sat(m_wait + 1);
    step(1'b0, 1'b0);
    chk("rstb_req2", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_rdata = '0; m_acc = 0; m_wait = 0; m_ea = 1'b0; m_et = 1'b0;
    #1;
    chk("rstb_req", 64'(mem_req), 64'd0);
    chk("rstb_stall", 64'(cpu_stall), 64'd0);
    chk("rstb_addr", mem_address, 64'd0);
    chk_regs("rstb");

    // Back-to-back loads until access_cnt saturates
    for (int k = 0; k < SAT + 3; k++)
      access(1'b0, 64'(k) << 3, 64'h0, {$urandom, $urandom}, 0, 0, busy, fault);
    chk("acc_saturated", 64'(access_cnt), 64'(SAT));

    for (int k = 0; k < 250; k++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom % 5 != 0) a[2:0] = 3'd0;
      access(1'($urandom % 2), a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 6)), 1, busy, fault);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
